ir_nec_tx: RTL
==============

Name: ir_nec_tx

Overview:
- NEC-protocol infrared transmitter. It is the sending end of the IR link whose receiver decodes 32-bit frames for motor commands.
- Takes an address/command pair (or a repeat request) and emits the modulated 38 kHz frame on an IR LED GPIO.
- Used by the handheld/remote-side board and for loopback testing of the robot's IR receive path.
- The bit order reproduces the receiver's 32-bit data word: {~cmd, cmd, ~addr, addr}, transmitted LSB first.

Parameters:
- UNIT_CYC, 28125: clock cycles per NEC time unit (562.5 us at 50 MHz).
- CARRIER_DIV, 1316: clock cycles per carrier period (about 38 kHz).
- CARRIER_HI, 439: cycles per carrier period that the carrier is high (about 1/3 duty).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- valid  in  1  frame request; accepted when valid && ready.
- addr  in  8  NEC address byte, sampled on accept.
- cmd  in  8  NEC command byte, sampled on accept.
- rpt  in  1  repeat-code request; accepted when rpt && ready && !valid.
- ready  out  1  block idle and able to accept a request.
- busy  out  1  frame, repeat code or inter-frame gap in progress.
- env  out  1  unmodulated envelope, high during marks.
- ir_out  out  1  carrier-modulated output: env AND carrier.

Behaviour:
- Reset values (applied asynchronously): state IDLE, ready=0, busy=0, env=0, ir_out=0, all counters 0. ready rises on the first clk edge after rst deasserts.
- On accept at edge N:
  - Latch shift register sr = {~cmd, cmd, ~addr, addr}.
  - ready=0 and busy=1 from N.
  - env=1 from N (first cycle after accept).
- State timing, all in units of UNIT_CYC:
  - IDLE -> LEAD_MARK (16) on valid, or on rpt.
  - LEAD_MARK -> LEAD_SPACE (8) for a frame, or -> RPT_SPACE (4) for a repeat code.
  - LEAD_SPACE -> BIT_MARK (1) -> BIT_SPACE (1 if sr[0]==0, 3 if sr[0]==1).
  - After BIT_SPACE: shift sr right and increment bit_idx. If bit_idx was 31 -> STOP_MARK (1), else -> BIT_MARK.
  - RPT_SPACE -> STOP_MARK.
  - STOP_MARK -> GAP.
  - GAP -> IDLE once 192 units (108 ms) have elapsed since the start of LEAD_MARK.
- env=1 only in LEAD_MARK, BIT_MARK and STOP_MARK.
- Counters:
  - Unit prescaler counts 0..UNIT_CYC-1.
  - Phase counter counts units within a state.
  - Frame counter counts 0..191 units from the start of LEAD_MARK and saturates; it does not wrap.
- Carrier:
  - Counter runs 0..CARRIER_DIV-1; carrier high while count < CARRIER_HI.
  - Counter is cleared at every transition into a mark state, so each mark starts with a high carrier.
  - ir_out is registered so it aligns with env.
- Full frame duration: 24 + 2*zeros + 4*ones + 1 units. For any valid frame (16 ones, 16 zeros) this is 121 units.
- Repeat-code duration: 21 units. Both frames and repeat codes pad to 192 units before returning to IDLE.
- Boundary conditions:
  - valid and rpt in the same cycle: valid wins, rpt is ignored, not queued.
  - valid or rpt while ready=0: ignored, no queuing, addr/cmd not sampled.
  - rst mid-frame: env and ir_out drop immediately, state returns to IDLE, no partial-frame completion.
  - Changes to addr/cmd after accept have no effect.

Decomposition:
- Package ir_nec_pkg holds:
  - state_t enum: IDLE, LEAD_MARK, LEAD_SPACE, RPT_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP.
  - Unit constants: LEAD_MARK_U=16, LEAD_SPACE_U=8, RPT_SPACE_U=4, BIT_MARK_U=1, ZERO_SPACE_U=1, ONE_SPACE_U=3, STOP_MARK_U=1, FRAME_U=192.
- One sub-module, ir_carrier_gen (inputs clk, rst, restart; output carrier), containing the carrier counter and comparator.
- The FSM and counters stay in ir_nec_tx.

Test Plan (UNIT_CYC=40, CARRIER_DIV=8, CARRIER_HI=3):
- Reset:
  - Stimulus: rst held 5 cycles, then released.
  - Response: env, ir_out and busy are 0 throughout; ready=0 during reset and 1 on the first edge after release.
- Frame, addr=0x00 cmd=0x02:
  - Envelope: env high 640 cycles, low 320.
  - Data bits: decoded mark/space widths give 0x00, 0xFF, 0x02, 0xFD, each LSB first.
  - Timing: stop mark 40 cycles; env=0 from unit 121; ready returns exactly 192*40 cycles after accept.
- Carrier:
  - During any mark, ir_out repeats the pattern 1,1,1,0,0,0,0,0 starting with 1 at each mark start.
  - ir_out=0 whenever env=0.
- Repeat:
  - Stimulus: rpt pulse while idle.
  - Response: env 640 high, 160 low, 40 high, then low; ready returns at 7680 cycles.
- Contention:
  - valid and rpt together -> a full frame is sent.
  - valid pulsed during GAP -> ignored, and ready timing is unchanged.
- Reset mid-operation:
  - Stimulus: rst asserted at bit 10.
  - Response: env/ir_out are 0 the same cycle; after release, a new frame with addr=0x5A cmd=0xC3 is transmitted correctly.

Source files
------------

// File: rtl/ir_nec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ir_nec_pkg
// Description : Shared types and constants for the NEC infrared transmitter.
//               Holds the transmitter state encoding, the length of each
//               state in NEC time units, and small helpers that classify
//               states and look up their lengths.
// Revision    : 1.0 - initial release
// ============================================================================
package ir_nec_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        RPT_SPACE  = 3'd3,
        BIT_MARK   = 3'd4,
        BIT_SPACE  = 3'd5,
        STOP_MARK  = 3'd6,
        GAP        = 3'd7
    } state_t;

    // State lengths in NEC time units (562.5 us each).
    localparam logic [7:0] LEAD_MARK_U  = 8'd16;
    localparam logic [7:0] LEAD_SPACE_U = 8'd8;
    localparam logic [7:0] RPT_SPACE_U  = 8'd4;
    localparam logic [7:0] BIT_MARK_U   = 8'd1;
    localparam logic [7:0] ZERO_SPACE_U = 8'd1;
    localparam logic [7:0] ONE_SPACE_U  = 8'd3;
    localparam logic [7:0] STOP_MARK_U  = 8'd1;
    // Frame-to-frame period: every frame or repeat code is padded to this.
    localparam logic [7:0] FRAME_U      = 8'd192;

    // Marks are the only states in which the LED envelope is on.
    function automatic logic is_mark(input state_t s);
        return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
    endfunction

    // Length of a state in units. BIT_SPACE depends on the bit being sent.
    // GAP ends on the frame counter, so its entry here is never consulted.
    function automatic logic [7:0] state_len(input state_t s, input logic one_bit);
        logic [7:0] len;
        case (s)
            LEAD_MARK:  len = LEAD_MARK_U;
            LEAD_SPACE: len = LEAD_SPACE_U;
            RPT_SPACE:  len = RPT_SPACE_U;
            BIT_MARK:   len = BIT_MARK_U;
            BIT_SPACE:  len = one_bit ? ONE_SPACE_U : ZERO_SPACE_U;
            STOP_MARK:  len = STOP_MARK_U;
            default:    len = 8'd1;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ir_carrier_gen.sv
`default_nettype none
// ============================================================================
// Module      : ir_carrier_gen
// Description : IR carrier generator. A counter runs 0..CARRIER_DIV-1 and
//               the carrier is high while the count is below CARRIER_HI.
//               restart forces the count back to 0 so a mark can begin on
//               the rising part of a carrier period.
// Ports       : clk     - system clock
//               rst     - asynchronous active-high reset
//               restart - clear the counter on this edge
//               carrier - carrier level for the cycle following the next
//                         clk edge (the caller registers it)
// Revision    : 1.0 - initial release
// ============================================================================
module ir_carrier_gen #(
    parameter int CARRIER_DIV = 1316,
    parameter int CARRIER_HI  = 439
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic carrier
);

    localparam int CW       = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam int CMAX_I   = CARRIER_DIV - 1;
    localparam int CONE_I   = 1;
    localparam logic [CW-1:0] CNT_MAX = CMAX_I[CW-1:0];
    localparam logic [CW-1:0] CNT_ONE = CONE_I[CW-1:0];
    // One extra bit so a 100 % duty setting (HI == DIV) still compares.
    localparam logic [CW:0]   HI_LIM  = CARRIER_HI[CW:0];

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_ONE;
        if (restart || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    // Compare the upcoming count so the top level can register the product
    // with the envelope and keep ir_out cycle-aligned with env.
    assign carrier = ({1'b0, cnt_d} < HI_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ir_nec_tx.sv
`default_nettype none
// ============================================================================
// Module      : ir_nec_tx
// Description : NEC infrared transmitter. Accepts an address/command pair or
//               a repeat request and emits the 38 kHz modulated frame.
//               Data word {~cmd, cmd, ~addr, addr} is sent LSB first; every
//               frame or repeat code is padded to 192 units before the block
//               becomes ready again.
// Ports       : clk    - system clock (50 MHz)
//               rst    - asynchronous active-high reset
//               valid  - frame request, accepted when valid && ready
//               addr   - NEC address byte, sampled on accept
//               cmd    - NEC command byte, sampled on accept
//               rpt    - repeat-code request, accepted when rpt && ready && !valid
//               ready  - idle and able to accept a request
//               busy   - frame, repeat code or gap in progress
//               env    - unmodulated envelope, high during marks
//               ir_out - envelope AND carrier
// Revision    : 1.0 - initial release
// ============================================================================
module ir_nec_tx
    import ir_nec_pkg::*;
#(
    parameter int UNIT_CYC    = 28125,
    parameter int CARRIER_DIV = 1316,
    parameter int CARRIER_HI  = 439
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
    input  logic       rpt,
    output logic       ready,
    output logic       busy,
    output logic       env,
    output logic       ir_out
);

    localparam int PRE_W    = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam int PMAX_I   = UNIT_CYC - 1;
    localparam int PONE_I   = 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PMAX_I[PRE_W-1:0];
    localparam logic [PRE_W-1:0] PRE_ONE = PONE_I[PRE_W-1:0];

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;       // cycles within the current unit
    logic [7:0]         ph_q, ph_d;         // units within the current state
    logic [7:0]         fr_q, fr_d;         // units since start of LEAD_MARK
    logic [31:0]        sr_q, sr_d;         // data bits still to send
    logic [4:0]         bit_idx_q, bit_idx_d;
    logic               rpt_q, rpt_d;       // current burst is a repeat code
    logic               ready_q, busy_q, env_q, ir_out_q;

    logic               w_tick;
    logic               w_ph_done;
    logic [7:0]         w_len;
    logic               w_state_chg;
    logic               w_mark_d;
    logic               w_restart;
    logic               w_carrier;

    assign w_tick    = (pre_q == PRE_MAX);
    assign w_len     = state_len(state_q, sr_q[0]);
    assign w_ph_done = w_tick && (ph_q == (w_len - 8'd1));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_idx_d = bit_idx_q;
        rpt_d     = rpt_q;
        case (state_q)
            IDLE: begin
                // valid has priority; a simultaneous rpt is simply dropped.
                if (ready_q && valid) begin
                    state_d   = LEAD_MARK;
                    sr_d      = {~cmd, cmd, ~addr, addr};
                    bit_idx_d = 5'd0;
                    rpt_d     = 1'b0;
                end else if (ready_q && rpt) begin
                    state_d   = LEAD_MARK;
                    bit_idx_d = 5'd0;
                    rpt_d     = 1'b1;
                end
            end
            LEAD_MARK: begin
                if (w_ph_done) begin
                    state_d = rpt_q ? RPT_SPACE : LEAD_SPACE;
                end
            end
            LEAD_SPACE: begin
                if (w_ph_done) begin
                    state_d = BIT_MARK;
                end
            end
            RPT_SPACE: begin
                if (w_ph_done) begin
                    state_d = STOP_MARK;
                end
            end
            BIT_MARK: begin
                if (w_ph_done) begin
                    state_d = BIT_SPACE;
                end
            end
            BIT_SPACE: begin
                if (w_ph_done) begin
                    sr_d      = {1'b0, sr_q[31:1]};
                    bit_idx_d = bit_idx_q + 5'd1;
                    state_d   = (bit_idx_q == 5'd31) ? STOP_MARK : BIT_MARK;
                end
            end
            STOP_MARK: begin
                if (w_ph_done) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                // fr_q holds completed units; the tick ending unit 192 exits.
                if (w_tick && (fr_q == (FRAME_U - 8'd1))) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign w_state_chg = (state_d != state_q);
    assign w_mark_d    = is_mark(state_d);
    // Every mark is entered from a non-mark state, so a state change into a
    // mark is exactly the start of a mark.
    assign w_restart   = w_mark_d && w_state_chg;

    // ------------------------------------------------------------------
    // Unit, phase and frame counters
    // ------------------------------------------------------------------
    always_comb begin
        pre_d = pre_q + PRE_ONE;
        ph_d  = ph_q;
        fr_d  = fr_q;
        if ((state_q == IDLE) || w_state_chg || w_tick) begin
            pre_d = '0;
        end
        if (w_state_chg) begin
            ph_d = 8'd0;
        end else if (w_tick) begin
            ph_d = ph_q + 8'd1;
        end
        if (state_q == IDLE) begin
            fr_d = 8'd0;
        end else if (w_tick && (fr_q != (FRAME_U - 8'd1))) begin
            fr_d = fr_q + 8'd1;
        end
    end

    ir_carrier_gen #(
        .CARRIER_DIV (CARRIER_DIV),
        .CARRIER_HI  (CARRIER_HI)
    ) u_carrier (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .carrier (w_carrier)
    );

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pre_q     <= '0;
            ph_q      <= 8'd0;
            fr_q      <= 8'd0;
            sr_q      <= 32'd0;
            bit_idx_q <= 5'd0;
            rpt_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            env_q     <= 1'b0;
            ir_out_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            ph_q      <= ph_d;
            fr_q      <= fr_d;
            sr_q      <= sr_d;
            bit_idx_q <= bit_idx_d;
            rpt_q     <= rpt_d;
            ready_q   <= (state_d == IDLE);
            busy_q    <= (state_d != IDLE);
            env_q     <= w_mark_d;
            ir_out_q  <= w_mark_d & w_carrier;
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign env    = env_q;
    assign ir_out = ir_out_q;

endmodule
`default_nettype wire
